// File: rtl/hazard_scoreboard.sv
// ============================================================================
//  Module   : hazard_scoreboard
//  Purpose  : Hazard and forwarding controller that sits beside Decode. It
//             keeps a shift-register scoreboard of in-flight destination
//             registers (entry 0 = EX ... entry DEPTH-1 = WB). From it, it
//             derives the EX operand forward selects, the branch-comparator
//             WB forward selects, and a load-use / branch-operand stall.
//  Ports    : clk, reset (async, active-high)
//             id_valid, id_rs1/id_rs2, id_rs1_used/id_rs2_used, id_rd,
//             id_regwrite, id_memread, id_branch, id_kill  -- Decode inputs
//             stall                 -- hold Fetch/Decode, bubble into EX
//             fwd1/fwd2 [FW_W]      -- 0 = register file, k+1 = entry k data
//             bfwd1/bfwd2           -- branch comparator takes WB data
//  Option   : HAZARD_PERF_CNT_EN adds cnt_clr (in) and stall_cnt[15:0] (out),
//             a saturating count of stalled cycles.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_scoreboard #(
  parameter int RA_W     = 3,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  parameter bit ZERO_REG = 1'b0,
  parameter int FW_W     = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic            id_rs1_used,
  input  logic            id_rs2_used,
  input  logic [RA_W-1:0] id_rd,
  input  logic            id_regwrite,
  input  logic            id_memread,
  input  logic            id_branch,
  input  logic            id_kill,
`ifdef HAZARD_PERF_CNT_EN
  input  logic            cnt_clr,
  output logic [15:0]     stall_cnt,
`endif
  output logic            stall,
  output logic [FW_W-1:0] fwd1,
  output logic [FW_W-1:0] fwd2,
  output logic            bfwd1,
  output logic            bfwd2
);

  // --------------------------------------------------------------------------
  // Scoreboard entries: {v, rd, wr, ld}. Entry k is k+1 stages past Decode.
  // --------------------------------------------------------------------------
  logic [DEPTH-1:0] v_q,  v_d;
  logic [DEPTH-1:0] wr_q, wr_d;
  logic [DEPTH-1:0] ld_q, ld_d;
  logic [RA_W-1:0]  rd_q [DEPTH];
  logic [RA_W-1:0]  rd_d [DEPTH];

  // Result of resolving one source operand against the scoreboard.
  typedef struct packed {
    logic            fwd_ok;   // youngest match is reachable by the EX bypass
    logic            at_wb;    // youngest match sits in the last tracked stage
    logic            ld_early; // youngest match is a load whose data is not ready
    logic [FW_W-1:0] sel;      // EX forward select for this operand
  } look_t;

  look_t look1;
  look_t look2;

  // Priority search: scanning oldest to youngest and overwriting on each hit
  // leaves the youngest (lowest index) match in the result.
  function automatic look_t lookup(input logic [RA_W-1:0] addr,
                                   input logic            used);
    look_t r;
    r = '0;
    if (id_valid && used && !(ZERO_REG && (addr == '0))) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (v_q[k] && wr_q[k] && (rd_q[k] == addr)) begin
          r.fwd_ok   = (k < DEPTH - 1);
          r.at_wb    = (k == DEPTH - 1);
          r.ld_early = ld_q[k] && (k < LOAD_LAT);
          // The last stage writes the register file through, so it reads as 0.
          r.sel      = (k < DEPTH - 1) ? FW_W'(k + 1) : '0;
        end
      end
    end
    return r;
  endfunction

  // --------------------------------------------------------------------------
  // Hazard resolution
  // --------------------------------------------------------------------------
  always_comb begin
    look1 = lookup(id_rs1, id_rs1_used);
    look2 = lookup(id_rs2, id_rs2_used);

    // Branches compare in Decode and only have a WB bypass, so any younger
    // producer forces a wait regardless of whether it is a load.
    stall = look1.ld_early | look2.ld_early |
            (id_branch & (look1.fwd_ok | look2.fwd_ok));

    fwd1  = look1.sel;
    fwd2  = look2.sel;
    bfwd1 = id_branch & look1.at_wb;
    bfwd2 = id_branch & look2.at_wb;
  end

  // --------------------------------------------------------------------------
  // Scoreboard shift. A stalled instruction is re-presented by Decode next
  // cycle, so it must not enter; a kill during a stall is ignored because the
  // stall already inserts the bubble and the jump decision was made on stale
  // operands.
  // --------------------------------------------------------------------------
  always_comb begin
    v_d     = v_q;
    wr_d    = wr_q;
    ld_d    = ld_q;
    rd_d    = rd_q;

    v_d[0]  = id_valid & ~stall & ~id_kill;
    wr_d[0] = id_regwrite;
    ld_d[0] = id_memread;
    rd_d[0] = id_rd;

    for (int k = 1; k < DEPTH; k++) begin
      v_d[k]  = v_q[k-1];
      wr_d[k] = wr_q[k-1];
      ld_d[k] = ld_q[k-1];
      rd_d[k] = rd_q[k-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q  <= '0;
      wr_q <= '0;
      ld_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        rd_q[k] <= '0;
      end
    end else begin
      v_q  <= v_d;
      wr_q <= wr_d;
      ld_q <= ld_d;
      for (int k = 0; k < DEPTH; k++) begin
        rd_q[k] <= rd_d[k];
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // --------------------------------------------------------------------------
  // Stall cycle counter: saturating, clear has priority over increment.
  // --------------------------------------------------------------------------
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = '0;
    end else if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
// ============================================================================
//  Module   : tb_hazard_scoreboard
//  Purpose  : Self-checking bench for hazard_scoreboard. A behavioural model
//             keeps the history of instructions issued into EX (one slot per
//             cycle, newest first) and derives the expected outputs from the
//             age of the most recent producer of each source register.
//             Two instances are used: default (ZERO_REG=0) and ZERO_REG=1.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_scoreboard;

  localparam int DEPTH    = 3;
  localparam int LOAD_LAT = 1;

  logic       clk;
  logic       reset;
  logic       id_valid;
  logic [2:0] id_rs1;
  logic [2:0] id_rs2;
  logic       id_rs1_used;
  logic       id_rs2_used;
  logic [2:0] id_rd;
  logic       id_regwrite;
  logic       id_memread;
  logic       id_branch;
  logic       id_kill;

  logic       stall,   stall_z;
  logic [1:0] fwd1,    fwd1_z;
  logic [1:0] fwd2,    fwd2_z;
  logic       bfwd1,   bfwd1_z;
  logic       bfwd2,   bfwd2_z;
`ifdef HAZARD_PERF_CNT_EN
  logic        cnt_clr;
  logic [15:0] stall_cnt, stall_cnt_z;
`endif

  int tests = 0;
  int fails = 0;

  hazard_scoreboard dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_branch(id_branch), .id_kill(id_kill),
`ifdef HAZARD_PERF_CNT_EN
    .cnt_clr(cnt_clr), .stall_cnt(stall_cnt),
`endif
    .stall(stall), .fwd1(fwd1), .fwd2(fwd2), .bfwd1(bfwd1), .bfwd2(bfwd2)
  );

  hazard_scoreboard #(.ZERO_REG(1'b1)) dut_z (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_branch(id_branch), .id_kill(id_kill),
`ifdef HAZARD_PERF_CNT_EN
    .cnt_clr(cnt_clr), .stall_cnt(stall_cnt_z),
`endif
    .stall(stall_z), .fwd1(fwd1_z), .fwd2(fwd2_z), .bfwd1(bfwd1_z), .bfwd2(bfwd2_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Behavioural model: issue history, index 0 = issued last cycle.
  // --------------------------------------------------------------------------
  typedef struct {
    bit       v;
    bit       wr;
    bit       ld;
    bit [2:0] rd;
  } slot_t;

  typedef struct {
    bit stall;
    int f1;
    int f2;
    bit b1;
    bit b2;
  } exp_t;

  slot_t hist0[$];   // history seen by the ZERO_REG=0 instance
  slot_t hist1[$];   // history seen by the ZERO_REG=1 instance

  // Age of the most recent writer of a, or -1 if none is in flight.
  function automatic int producer_age(input slot_t h[$], input bit [2:0] a,
                                      input bit used, input bit zreg);
    if (!id_valid || !used) return -1;
    if (zreg && a == 3'd0) return -1;
    for (int i = 0; i < h.size(); i++) begin
      if (h[i].v && h[i].wr && h[i].rd == a) return i;
    end
    return -1;
  endfunction

  function automatic exp_t model(input slot_t h[$], input bit zreg);
    exp_t e;
    int a1, a2;
    bit lu1, lu2, near1, near2;
    a1    = producer_age(h, id_rs1, id_rs1_used, zreg);
    a2    = producer_age(h, id_rs2, id_rs2_used, zreg);
    near1 = (a1 >= 0) && (a1 < DEPTH - 1);
    near2 = (a2 >= 0) && (a2 < DEPTH - 1);
    lu1   = (a1 >= 0) && (a1 < LOAD_LAT) && h[a1].ld;
    lu2   = (a2 >= 0) && (a2 < LOAD_LAT) && h[a2].ld;
    e.f1    = near1 ? a1 + 1 : 0;
    e.f2    = near2 ? a2 + 1 : 0;
    e.stall = lu1 || lu2 || (id_branch && (near1 || near2));
    e.b1    = id_branch && (a1 == DEPTH - 1);
    e.b2    = id_branch && (a2 == DEPTH - 1);
    return e;
  endfunction

  function automatic slot_t issued(input bit stalled);
    slot_t s;
    s.v  = id_valid && !stalled && !id_kill;
    s.wr = id_regwrite;
    s.ld = id_memread;
    s.rd = id_rd;
    return s;
  endfunction

  always @(posedge clk or posedge reset) begin
    exp_t e0, e1;
    if (reset) begin
      hist0.delete();
      hist1.delete();
    end else begin
      e0 = model(hist0, 1'b0);
      e1 = model(hist1, 1'b1);
      hist0.push_front(issued(e0.stall));
      hist1.push_front(issued(e1.stall));
      if (hist0.size() > DEPTH) void'(hist0.pop_back());
      if (hist1.size() > DEPTH) void'(hist1.pop_back());
    end
  end

  // --------------------------------------------------------------------------
  // Checking
  // --------------------------------------------------------------------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare process: both instances against the model every cycle.
  always @(negedge clk) begin
    exp_t e0, e1;
    e0 = model(hist0, 1'b0);
    e1 = model(hist1, 1'b1);
    chk("model.stall", {31'd0, stall}, {31'd0, e0.stall});
    chk("model.fwd1",  {30'd0, fwd1},  e0.f1);
    chk("model.fwd2",  {30'd0, fwd2},  e0.f2);
    chk("model.bfwd1", {31'd0, bfwd1}, {31'd0, e0.b1});
    chk("model.bfwd2", {31'd0, bfwd2}, {31'd0, e0.b2});
    chk("model_z.stall", {31'd0, stall_z}, {31'd0, e1.stall});
    chk("model_z.fwd1",  {30'd0, fwd1_z},  e1.f1);
    chk("model_z.fwd2",  {30'd0, fwd2_z},  e1.f2);
    chk("model_z.bfwd1", {31'd0, bfwd1_z}, {31'd0, e1.b1});
    chk("model_z.bfwd2", {31'd0, bfwd2_z}, {31'd0, e1.b2});
  end

  // Hand-computed expectations for the default instance.
  task automatic expect_out(input string nm, input bit s, input int f1, input int f2,
                            input bit b1, input bit b2);
    #1;
    chk({nm, ".stall"}, {31'd0, stall}, {31'd0, s});
    chk({nm, ".fwd1"},  {30'd0, fwd1},  f1);
    chk({nm, ".fwd2"},  {30'd0, fwd2},  f2);
    chk({nm, ".bfwd1"}, {31'd0, bfwd1}, {31'd0, b1});
    chk({nm, ".bfwd2"}, {31'd0, bfwd2}, {31'd0, b2});
  endtask

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic drive(input bit v, input bit [2:0] rs1, input bit u1,
                       input bit [2:0] rs2, input bit u2, input bit [2:0] rd,
                       input bit rw, input bit mr, input bit br, input bit kill);
    id_valid    = v;
    id_rs1      = rs1;
    id_rs1_used = u1;
    id_rs2      = rs2;
    id_rs2_used = u2;
    id_rd       = rd;
    id_regwrite = rw;
    id_memread  = mr;
    id_branch   = br;
    id_kill     = kill;
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    idle();
    repeat (DEPTH) tick();
  endtask

  // Producer writing rd (optionally a load).
  task automatic prod(input bit [2:0] rd, input bit mr);
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, rd, 1'b1, mr, 1'b0, 1'b0);
  endtask

  // Valid instruction that neither reads nor writes registers.
  task automatic nop_instr();
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  initial begin
    reset = 1'b1;
`ifdef HAZARD_PERF_CNT_EN
    cnt_clr = 1'b0;
`endif
    idle();
    tick();
    expect_out("reset_idle", 0, 0, 0, 0, 0);
    tick();
    reset = 1'b0;

    // Mid-stream asynchronous reset with a live match present.
    prod(3'd3, 1'b0);
    tick();
    drive(1'b1, 3'd3, 1'b1, 3'd3, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_out("pre_reset", 0, 1, 1, 0, 0);
    reset = 1'b1;
    expect_out("async_reset", 0, 0, 0, 0, 0);
    tick();
    reset = 1'b0;
    expect_out("after_reset", 0, 0, 0, 0, 0);
    tick();

    // Forwarding distance 1, 2, 3.
    flush();
    prod(3'd3, 1'b0); tick();
    drive(1'b1, 3'd3, 1'b1, 3'd5, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_out("fwd_dist1", 0, 1, 0, 0, 0);
    tick();
    flush();
    prod(3'd3, 1'b0); tick();
    nop_instr(); tick();
    drive(1'b1, 3'd3, 1'b1, 3'd5, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_out("fwd_dist2", 0, 2, 0, 0, 0);
    tick();
    flush();
    prod(3'd3, 1'b0); tick();
    nop_instr(); tick();
    nop_instr(); tick();
    drive(1'b1, 3'd3, 1'b1, 3'd5, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_out("fwd_dist3", 0, 0, 0, 0, 0);
    tick();

    // Load-use: one stall cycle, then forward from WB.
    flush();
    prod(3'd2, 1'b1); tick();
    drive(1'b1, 3'd2, 1'b1, 3'd2, 1'b1, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_out("load_use_stall", 1, 1, 1, 0, 0);
    tick();
    expect_out("load_use_resolved", 0, 2, 2, 0, 0);
    tick();

    // Branch on a just-produced register: two stall cycles, then WB bypass.
    flush();
    prod(3'd1, 1'b0); tick();
    drive(1'b1, 3'd1, 1'b1, 3'd7, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_out("branch_stall0", 1, 1, 0, 0, 0);
    tick();
    expect_out("branch_stall1", 1, 2, 0, 0, 0);
    tick();
    expect_out("branch_resolved", 0, 0, 0, 1, 0);
    tick();

    // Same, with a kill during the stall: ignored, the instruction still issues.
    flush();
    prod(3'd1, 1'b0); tick();
    drive(1'b1, 3'd1, 1'b1, 3'd7, 1'b1, 3'd6, 1'b1, 1'b0, 1'b1, 1'b1);
    expect_out("kill_stall0", 1, 1, 0, 0, 0);
    tick();
    expect_out("kill_stall1", 1, 2, 0, 0, 0);
    tick();
    id_kill = 1'b0;
    expect_out("kill_resolved", 0, 0, 0, 1, 0);
    tick();
    drive(1'b1, 3'd6, 1'b1, 3'd0, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_out("kill_branch_kept", 0, 1, 0, 0, 0);
    tick();

    // Kill without a stall inserts a bubble.
    flush();
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd6, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b1, 3'd6, 1'b1, 3'd0, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_out("kill_bubble", 0, 0, 0, 0, 0);
    tick();

    // Two producers of r5: youngest wins.
    flush();
    prod(3'd5, 1'b0); tick();
    prod(3'd5, 1'b0); tick();
    drive(1'b1, 3'd5, 1'b1, 3'd5, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_out("youngest_wins", 0, 1, 1, 0, 0);
    tick();

    // r0 producer/consumer: matches only when r0 is not hardwired.
    flush();
    prod(3'd0, 1'b1); tick();
    drive(1'b1, 3'd0, 1'b1, 3'd0, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_out("r0_plain", 1, 1, 1, 0, 0);
    chk("r0_zero.stall", {31'd0, stall_z}, 32'd0);
    chk("r0_zero.fwd1",  {30'd0, fwd1_z},  32'd0);
    chk("r0_zero.fwd2",  {30'd0, fwd2_z},  32'd0);
    tick();
    flush();

`ifdef HAZARD_PERF_CNT_EN
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    repeat (3) begin
      prod(3'd2, 1'b1); tick();
      drive(1'b1, 3'd2, 1'b1, 3'd0, 1'b0, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0);
      tick(); tick();
      idle();
    end
    chk("stall_cnt_three", {16'd0, stall_cnt}, 32'd3);
    prod(3'd2, 1'b1); tick();
    drive(1'b1, 3'd2, 1'b1, 3'd0, 1'b0, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("stall_cnt_clr_wins", {16'd0, stall_cnt}, 32'd0);
    tick();
    flush();
`endif

    // Randomised traffic with occasional asynchronous resets.
    for (int i = 0; i < 800; i++) begin
      drive($urandom_range(0, 9) != 0,
            3'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
            3'($urandom_range(0, 7)), $urandom_range(0, 1) != 0,
            3'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 9) == 0);
      if ($urandom_range(0, 59) == 0) begin
        reset = 1'b1;
        expect_out("rand_reset", 0, 0, 0, 0, 0);
        tick();
        reset = 1'b0;
      end else begin
        tick();
      end
    end

    idle();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised hazard and forwarding controller for the in-order pipelined CPU. Successor to the fixed 3-bit-address forwarding unit.
- Owns its own shift-register scoreboard of in-flight destination registers, so stage rd/RegWrite signals no longer need to be routed back to it.
- Sits beside Decode. Outputs per-operand EX forwarding selects, branch-comparator forward selects, and a load-use/branch stall.
- Generalised in register-address width, pipeline depth and load latency.

Parameters:
- RA_W, 3: register address width.
- DEPTH, 3: tracked stages after Decode (entry 0 = EX ... entry DEPTH-1 = WB); legal range 2..7.
- LOAD_LAT, 1: number of youngest entries in which a load result is not yet forwardable.
- ZERO_REG, 0: 1 = register 0 is hardwired zero and never matches.
- FW_W, 2: forward-select width; must be at least clog2(DEPTH).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- id_valid  in  1  Decode holds a real instruction
- id_rs1  in  RA_W  source 1 address
- id_rs2  in  RA_W  source 2 address
- id_rs1_used  in  1  source 1 is read
- id_rs2_used  in  1  source 2 is read
- id_rd  in  RA_W  destination address
- id_regwrite  in  1  instruction writes rd
- id_memread  in  1  instruction is a load
- id_branch  in  1  sources are compared in Decode
- id_kill  in  1  squash the Decode instruction (taken jump)
- stall  out  1  hold Fetch/Decode; bubble into EX
- fwd1  out  FW_W  EX operand-1 select
- fwd2  out  FW_W  EX operand-2 select
- bfwd1  out  1  comparator 1 takes WB data
- bfwd2  out  1  comparator 2 takes WB data

Behaviour:
- State: DEPTH entries, each holding {v, rd, wr, ld}. An entry is "live" when v&wr.
- Every clock, entries shift: entry k to k+1, and entry DEPTH-1 is dropped.
- Entry 0 loads the Decode instruction when id_valid & !stall & !id_kill. Otherwise it loads a bubble (v=0).
- Reset, asynchronous: all v cleared. Outputs are therefore stall=0, fwd1=fwd2=0, bfwd1=bfwd2=0 during and immediately after reset.
- Reset released mid-program: the pipeline restarts empty, with no stale matches.
- Match for operand s: id_valid & s_used & live entry k & rd==s, and not (ZERO_REG & s==0). The youngest (lowest k) match wins.
- fwd_s, combinational, is registered by Decode into ID/EX:
  - k+1 when the youngest match k < DEPTH-1. Code 1 = MEM ALU result, 2 = WB data, and so on.
  - 0 (register file) when there is no match or the match is k = DEPTH-1. The register file is write-through.
- Load-use stall: the youngest match is a load (ld=1) with k < LOAD_LAT.
- Branch operands (id_branch=1):
  - Youngest match k < DEPTH-1 of any type: stall.
  - Youngest match k = DEPTH-1: bfwd_s=1.
  - Otherwise bfwd_s=0.
  - bfwd is 0 whenever id_branch=0.
- stall = OR of the load-use and branch terms for both operands. It is combinational from the current state and id_* inputs.
- While stall=1, fwd/bfwd outputs are don't-care, but must be deterministic (computed by the same rules).
- Decode re-presents the held instruction the next cycle. Bubbles drain, so the stall self-clears: at most LOAD_LAT cycles for load-use, and at most DEPTH-1 cycles for branches.
- id_kill with stall=1: stall dominates. The kill is ignored, because a jump decided on stale operands is invalid.
- id_kill with stall=0: a bubble is inserted.
- Same register in both operands: each operand is resolved independently. Two matching entries: youngest wins.
- No arithmetic beyond compare and priority encode. All widths derive from the parameters. Implementation is roughly 150-250 lines.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - Adds output stall_cnt [15:0], counting cycles with stall=1.
  - Saturates at 16'hFFFF with no wrap.
  - Cleared by reset.
  - Adds input cnt_clr [0:0], which clears the counter synchronously. cnt_clr wins over a simultaneous increment.
- Undefined: neither port exists, and the core behaviour is identical.

Test Plan:
All scenarios use defaults (DEPTH=3, LOAD_LAT=1).
- Reset asserted mid-stream with entries live -> stall=0 and fwd1=fwd2=0 immediately (asynchronous); the first instruction after release sees no matches.
- Producer "add r3" issued, then "sub r4,r3,r5" next cycle -> fwd1=1, stall=0. With one unrelated instruction between them -> fwd1=2. With two between them -> fwd1=0.
- "load r2" then "add r6,r2,r2" -> stall=1 for exactly 1 cycle, then fwd1=fwd2=2, and a bubble is observed in entry 0.
- "add r1" then "beq r1,r7" -> stall for 2 cycles, then bfwd1=1, bfwd2=0. The same sequence with id_kill=1 during the stall -> the kill is ignored and the branch is not lost.
- Two producers of r5 back-to-back, then a consumer -> fwd=1 (youngest wins). With ZERO_REG=1, a producer and consumer of r0 -> fwd=0 and no stall.
- With HAZARD_PERF_CNT_EN defined: 3 load-use stalls -> stall_cnt=3; cnt_clr=1 in the same cycle as a stall -> stall_cnt=0.
